// File: rtl/platform_scroll_ctrl_if.sv
// Bundle of the platform table controller's command, random-source and table-read signals.
interface platform_scroll_ctrl_if #(
    parameter int N = 16
);
    logic             start_init;
    logic             frame_tick;
    logic [3:0]       scroll_dy;
    logic             rand_req;
    logic             rand_valid;
    logic [8:0]       rand_data;
    logic [9*N-1:0]   plat_x_flat;
    logic [9*N-1:0]   plat_y_flat;
    logic             table_valid;
    logic             busy;
    logic             done;
    logic             overrun;
    logic [15:0]      score;

    // Environment side: game logic, LFSR chain and colour mapper.
    modport master (
        output start_init,
        output frame_tick,
        output scroll_dy,
        output rand_valid,
        output rand_data,
        input  rand_req,
        input  plat_x_flat,
        input  plat_y_flat,
        input  table_valid,
        input  busy,
        input  done,
        input  overrun,
        input  score
    );

    // Controller side.
    modport slave (
        input  start_init,
        input  frame_tick,
        input  scroll_dy,
        input  rand_valid,
        input  rand_data,
        output rand_req,
        output plat_x_flat,
        output plat_y_flat,
        output table_valid,
        output busy,
        output done,
        output overrun,
        output score
    );
endinterface

// File: rtl/platform_scroll_ctrl.sv
// Platform position table controller: builds the table from the LFSR chain on start_init,
// scrolls every slot down by scroll_dy on each frame_tick, and re-randomises slots that
// fall off the bottom of the screen (counting each such wrap in score).
module platform_scroll_ctrl #(
    parameter int N         = 16,
    parameter int Y_TOP     = 30,
    parameter int Y_SPACING = 30,
    parameter int Y_MAX     = 479,
    parameter int X_MIN     = 100,
    parameter int X_SPAN    = 400
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    platform_scroll_ctrl_if.slave bus
);
    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [9:0]    Y_MAX_10 = 10'(Y_MAX);
    localparam logic [9:0]    WRAP_SUB = 10'(N * Y_SPACING);
    localparam logic [8:0]    X_MIN_9  = 9'(X_MIN);
    localparam logic [8:0]    X_SPAN_9 = 9'(X_SPAN);
    localparam logic [8:0]    Y_TOP_9  = 9'(Y_TOP);
    localparam logic [8:0]    Y_STEP_9 = 9'(Y_SPACING);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_REQ  = 3'd1,
        S_SCAN      = 3'd2,
        S_RAND_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    // Fold a raw random value into the X window; a single subtraction suffices
    // because the raw value is below 2*X_SPAN whenever X_SPAN >= 256.
    function automatic logic [8:0] xmap(input logic [8:0] r);
        logic [8:0] off;
        if (r >= X_SPAN_9) begin
            off = r - X_SPAN_9;
        end else begin
            off = r;
        end
        return X_MIN_9 + off;
    endfunction

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [3:0]     dy_q;
    logic [15:0]    score_q;
    logic           overrun_q;
    logic           table_valid_q;
    logic [8:0]     x_q [N];
    logic [8:0]     y_q [N];

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rand_req_q, rand_req_d;

    logic           hs_s;
    logic           last_s;
    logic [9:0]     ny_s;
    logic           wrap_s;
    logic [8:0]     ny_wrap_s;
    logic [8:0]     init_y_s;
    logic [8:0]     new_x_s;
    logic [9*N-1:0] x_flat_s;
    logic [9*N-1:0] y_flat_s;

    // Per-slot arithmetic for the slot currently addressed by idx_q.
    always_comb begin
        hs_s      = rand_req_q & bus.rand_valid;
        last_s    = (idx_q == IDX_LAST);
        ny_s      = {1'b0, y_q[idx_q]} + {6'd0, dy_q};
        wrap_s    = (ny_s > Y_MAX_10);
        ny_wrap_s = 9'(ny_s - WRAP_SUB);
        init_y_s  = Y_TOP_9 + (9'(idx_q) * Y_STEP_9);
        new_x_s   = xmap(bus.rand_data);
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start_init pre-empts everything, including a pending tick.
    always_comb begin
        state_d = state_q;
        if (bus.start_init) begin
            state_d = S_INIT_REQ;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_tick && table_valid_q) begin
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_INIT_REQ: begin
                    if (hs_s && last_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_INIT_REQ;
                    end
                end
                S_SCAN: begin
                    if (wrap_s) begin
                        state_d = S_RAND_WAIT;
                    end else if (last_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
                S_RAND_WAIT: begin
                    if (!hs_s) begin
                        state_d = S_RAND_WAIT;
                    end else if (last_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with the state.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        rand_req_d = (state_d == S_INIT_REQ) || (state_d == S_RAND_WAIT);
    end

    // Registered status and handshake outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rand_req_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            rand_req_q <= rand_req_d;
        end
    end

    // Slot index, sampled scroll step, score, overrun flag and table-valid flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q         <= '0;
            dy_q          <= 4'd0;
            score_q       <= 16'd0;
            overrun_q     <= 1'b0;
            table_valid_q <= 1'b0;
        end else if (bus.start_init) begin
            idx_q         <= '0;
            score_q       <= 16'd0;
            overrun_q     <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            if (bus.frame_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_tick && table_valid_q) begin
                        idx_q <= '0;
                        dy_q  <= bus.scroll_dy;
                    end
                end
                S_INIT_REQ: begin
                    if (hs_s) begin
                        if (last_s) begin
                            table_valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                S_SCAN: begin
                    if (!wrap_s && !last_s) begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_RAND_WAIT: begin
                    if (hs_s) begin
                        if (score_q != 16'hFFFF) begin
                            score_q <= score_q + 16'd1;
                        end
                        if (!last_s) begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    idx_q <= '0;
                end
                default: begin
                    idx_q <= '0;
                end
            endcase
        end
    end

    // Position table writes: init fills X and the Y ladder, scans move Y, wraps refresh X.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) begin
                x_q[i] <= 9'd0;
                y_q[i] <= 9'd0;
            end
        end else if (!bus.start_init) begin
            case (state_q)
                S_INIT_REQ: begin
                    if (hs_s) begin
                        x_q[idx_q] <= new_x_s;
                        y_q[idx_q] <= init_y_s;
                    end
                end
                S_SCAN: begin
                    if (wrap_s) begin
                        y_q[idx_q] <= ny_wrap_s;
                    end else begin
                        y_q[idx_q] <= ny_s[8:0];
                    end
                end
                S_RAND_WAIT: begin
                    if (hs_s) begin
                        x_q[idx_q] <= new_x_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the table onto the buses read by the colour mapper.
    always_comb begin
        x_flat_s = '0;
        y_flat_s = '0;
        for (int i = 0; i < N; i++) begin
            x_flat_s[9*i +: 9] = x_q[i];
            y_flat_s[9*i +: 9] = y_q[i];
        end
    end

    assign bus.plat_x_flat = x_flat_s;
    assign bus.plat_y_flat = y_flat_s;
    assign bus.table_valid = table_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rand_req    = rand_req_q;
    assign bus.overrun     = overrun_q;
    assign bus.score       = score_q;

endmodule
